// File: rtl/hdmi_rgb565_pack_if.sv
// Pixel-side bus of hdmi_rgb565_pack: ADV7611 video in, packed frame-buffer words and error flags out.
interface hdmi_rgb565_pack_if;
  logic        vin_vsync;
  logic        vin_de;
  logic [23:0] vin_data;
  logic        err_clr;
  logic        wframe_vsync;
  logic        wframe_data_en;
  logic [63:0] wframe_data;
  logic        line_err;
  logic        frame_err;

  modport master (
    output vin_vsync, vin_de, vin_data, err_clr,
    input  wframe_vsync, wframe_data_en, wframe_data, line_err, frame_err
  );

  modport slave (
    input  vin_vsync, vin_de, vin_data, err_clr,
    output wframe_vsync, wframe_data_en, wframe_data, line_err, frame_err
  );
endinterface

// File: rtl/hdmi_rgb565_pack.sv
// Converts ADV7611 RGB888 to RGB565, crops to H_ACTIVE x V_ACTIVE and packs four pixels
// per 64-bit word for the frame-buffer write FIFO. Two-stage pipe: input register, then pack/output.
module hdmi_rgb565_pack #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic        VS_POL   = 1'b1
) (
  input logic               wframe_pclk,
  input logic               wframe_rst,
  hdmi_rgb565_pack_if.slave bus
);

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_SYNC,
    S_FRAME,
    S_LINE,
    S_LINE_END
  } state_t;

  state_t      state_q, state_d;
  logic        vs1_q;
  logic        de1_q;
  logic [15:0] pix1_q;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [1:0]  lane_q, lane_d;
  logic [63:0] pack_q, pack_d;
  logic        vsync_q;
  logic        data_en_q, data_en_d;
  logic [63:0] data_q, data_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic        vs_rise;
  logic        pix_en;
  logic [10:0] y_end;

  // vsync_q is the stage-1 vsync one cycle later, so it doubles as the edge-detect history.
  assign vs_rise = vs1_q & ~vsync_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    data_en_d   = 1'b0;
    data_d      = data_q;
    line_err_d  = line_err_q & ~bus.err_clr;
    frame_err_d = frame_err_q & ~bus.err_clr;
    pix_en      = 1'b0;
    y_end       = (y_q == CNT_MAX) ? y_q : y_q + 11'd1;

    case (state_q)
      S_SYNC: begin
        if (vs_rise) begin
          state_d = S_FRAME;
          x_d     = '0;
          y_d     = '0;
          lane_d  = '0;
          pack_d  = '0;
        end
      end

      S_FRAME, S_LINE_END: begin
        state_d = S_FRAME;
        if (vs_rise) begin
          if (y_q != V_LIM) frame_err_d = 1'b1;
          x_d    = '0;
          y_d    = '0;
          lane_d = '0;
          pack_d = '0;
        end
        if (de1_q) begin
          state_d = S_LINE;
          pix_en  = 1'b1;
        end
      end

      S_LINE: begin
        // A vsync edge inside a line closes the line first, then runs the frame check on the updated count.
        if (!de1_q || vs_rise) begin
          if (lane_q != 2'd0) begin
            data_en_d = 1'b1;
            data_d    = pack_q;
          end
          if (y_q < V_LIM && x_q != H_LIM) line_err_d = 1'b1;
          x_d     = '0;
          lane_d  = '0;
          pack_d  = '0;
          y_d     = y_end;
          state_d = S_LINE_END;
          if (vs_rise) begin
            if (y_end != V_LIM) frame_err_d = 1'b1;
            y_d     = '0;
            state_d = S_FRAME;
          end
        end else begin
          pix_en = 1'b1;
        end
      end

      default: state_d = S_SYNC;
    endcase

    if (pix_en && x_d < H_LIM && y_d < V_LIM) begin
      if (lane_d == 2'd3) begin
        data_en_d = 1'b1;
        data_d    = {pix1_q, pack_d[47:0]};
        pack_d    = '0;
        lane_d    = '0;
      end else begin
        pack_d[{lane_d, 4'b0000} +: 16] = pix1_q;
        lane_d = lane_d + 2'd1;
      end
    end
    if (pix_en && x_d != CNT_MAX) x_d = x_d + 11'd1;
  end

  always_ff @(posedge wframe_pclk or posedge wframe_rst) begin
    if (wframe_rst) begin
      vs1_q       <= 1'b0;
      de1_q       <= 1'b0;
      pix1_q      <= '0;
      state_q     <= S_SYNC;
      x_q         <= '0;
      y_q         <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      vsync_q     <= 1'b0;
      data_en_q   <= 1'b0;
      data_q      <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vs1_q       <= bus.vin_vsync ^ ~VS_POL;
      de1_q       <= bus.vin_de;
      pix1_q      <= {bus.vin_data[23:19], bus.vin_data[15:10], bus.vin_data[7:3]};
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      vsync_q     <= vs1_q;
      data_en_q   <= data_en_d;
      data_q      <= data_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.wframe_vsync   = vsync_q;
  assign bus.wframe_data_en = data_en_q;
  assign bus.wframe_data    = data_q;
  assign bus.line_err       = line_err_q;
  assign bus.frame_err      = frame_err_q;

endmodule
